// File: rtl/seg_display_driver.sv
// Multiplexed seven-segment driver: hex or binary-to-BCD decimal display with
// leading-zero blanking, per-digit blink and decimal points, scanned one digit per slot.
module seg_display_driver #(
   parameter int DIGIT_CNT = 8,
   parameter int SCAN_DIV  = 100000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic                   clk_100M,
   input  logic                   reset,
   input  logic                   load_valid,
   output logic                   load_ready,
   input  logic [4*DIGIT_CNT-1:0] number,
   input  logic                   dec_mode,
   input  logic                   blank_lz,
   input  logic [DIGIT_CNT-1:0]   blink_mask,
   input  logic [DIGIT_CNT-1:0]   dp,
   output logic                   busy,
   output logic [DIGIT_CNT-1:0]   digit,
   output logic [7:0]             segment
);

   localparam int NUM_W   = 4 * DIGIT_CNT;
   localparam int BCD_DIG = DIGIT_CNT + DIGIT_CNT / 4 + 1;
   localparam int BCD_W   = 4 * BCD_DIG;
   localparam int IDX_W   = (DIGIT_CNT > 1) ? $clog2(DIGIT_CNT) : 1;
   localparam int SCAN_W  = $clog2(SCAN_DIV);
   localparam int BLINK_W = $clog2(BLINK_DIV);
   localparam int CNT_W   = $clog2(NUM_W);

   localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);
   localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(DIGIT_CNT - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(NUM_W - 1);

   typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      r = v;
      for (int i = 0; i < BCD_DIG; i++) begin
         if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] nib);
      case (nib)
         4'h0: seg7 = 7'h3F;
         4'h1: seg7 = 7'h06;
         4'h2: seg7 = 7'h5B;
         4'h3: seg7 = 7'h4F;
         4'h4: seg7 = 7'h66;
         4'h5: seg7 = 7'h6D;
         4'h6: seg7 = 7'h7D;
         4'h7: seg7 = 7'h07;
         4'h8: seg7 = 7'h7F;
         4'h9: seg7 = 7'h6F;
         4'hA: seg7 = 7'h77;
         4'hB: seg7 = 7'h7C;
         4'hC: seg7 = 7'h39;
         4'hD: seg7 = 7'h5E;
         4'hE: seg7 = 7'h79;
         default: seg7 = 7'h71;
      endcase
   endfunction

   state_t               state_q, state_d;
   logic [SCAN_W-1:0]    scan_q, scan_d;
   logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
   logic                 phase_q, phase_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [NUM_W-1:0]     disp_q, disp_d;
   logic                 ovf_q, ovf_d;
   logic                 lz_q, lz_d;
   logic [DIGIT_CNT-1:0] blink_q, blink_d;
   logic [DIGIT_CNT-1:0] dp_q, dp_d;
   logic                 pend_lz_q, pend_lz_d;
   logic [DIGIT_CNT-1:0] pend_blink_q, pend_blink_d;
   logic [DIGIT_CNT-1:0] pend_dp_q, pend_dp_d;
   logic [NUM_W-1:0]     bin_q, bin_d;
   logic [BCD_W-1:0]     bcd_q, bcd_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [DIGIT_CNT-1:0] digit_q, digit_d;
   logic [7:0]           seg_q, seg_d;

   logic [BCD_W-1:0]     bcd_adj;
   logic [3:0]           nib;
   logic                 hi_zero;
   logic                 blanked;

   assign load_ready = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign digit      = digit_q;
   assign segment    = seg_q;

   always_comb begin
      state_d      = state_q;
      scan_d       = scan_q + SCAN_W'(1);
      blink_cnt_d  = blink_cnt_q + BLINK_W'(1);
      phase_d      = phase_q;
      idx_d        = idx_q;
      disp_d       = disp_q;
      ovf_d        = ovf_q;
      lz_d         = lz_q;
      blink_d      = blink_q;
      dp_d         = dp_q;
      pend_lz_d    = pend_lz_q;
      pend_blink_d = pend_blink_q;
      pend_dp_d    = pend_dp_q;
      bin_d        = bin_q;
      bcd_d        = bcd_q;
      cnt_d        = cnt_q;
      bcd_adj      = add3(bcd_q);

      if (scan_q == SCAN_MAX) begin
         scan_d = '0;
         idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
      end
      if (blink_cnt_q == BLINK_MAX) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end

      case (state_q)
         IDLE: begin
            if (load_valid) begin
               if (dec_mode) begin
                  // Decimal config is parked until the converted value lands.
                  pend_lz_d    = blank_lz;
                  pend_blink_d = blink_mask;
                  pend_dp_d    = dp;
                  bin_d        = number;
                  bcd_d        = '0;
                  cnt_d        = '0;
                  state_d      = CONVERT;
               end else begin
                  disp_d  = number;
                  ovf_d   = 1'b0;
                  lz_d    = blank_lz;
                  blink_d = blink_mask;
                  dp_d    = dp;
               end
            end
         end
         CONVERT: begin
            bcd_d = {bcd_adj[BCD_W-2:0], bin_q[NUM_W-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_MAX) state_d = UPDATE;
         end
         UPDATE: begin
            disp_d  = bcd_q[NUM_W-1:0];
            ovf_d   = |bcd_q[BCD_W-1:NUM_W];
            lz_d    = pend_lz_q;
            blink_d = pend_blink_q;
            dp_d    = pend_dp_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Digit at idx and everything above it are zero when the shifted register is empty.
      nib     = disp_q[4*idx_q +: 4];
      hi_zero = ((disp_q >> (4*idx_q)) == '0);
      blanked = (phase_q & blink_q[idx_q]) |
                (lz_q & ~ovf_q & (idx_q != '0) & hi_zero);
      digit_d = blanked ? '0 : (DIGIT_CNT'(1) << idx_q);
      seg_d   = {dp_q[idx_q], ovf_q ? 7'h40 : seg7(nib)};
   end

   always_ff @(posedge clk_100M) begin
      if (reset) begin
         state_q      <= IDLE;
         scan_q       <= '0;
         blink_cnt_q  <= '0;
         phase_q      <= 1'b0;
         idx_q        <= '0;
         disp_q       <= '0;
         ovf_q        <= 1'b0;
         lz_q         <= 1'b0;
         blink_q      <= '0;
         dp_q         <= '0;
         pend_lz_q    <= 1'b0;
         pend_blink_q <= '0;
         pend_dp_q    <= '0;
         bin_q        <= '0;
         bcd_q        <= '0;
         cnt_q        <= '0;
         digit_q      <= DIGIT_CNT'(1);
         seg_q        <= 8'h3F;
      end else begin
         state_q      <= state_d;
         scan_q       <= scan_d;
         blink_cnt_q  <= blink_cnt_d;
         phase_q      <= phase_d;
         idx_q        <= idx_d;
         disp_q       <= disp_d;
         ovf_q        <= ovf_d;
         lz_q         <= lz_d;
         blink_q      <= blink_d;
         dp_q         <= dp_d;
         pend_lz_q    <= pend_lz_d;
         pend_blink_q <= pend_blink_d;
         pend_dp_q    <= pend_dp_d;
         bin_q        <= bin_d;
         bcd_q        <= bcd_d;
         cnt_q        <= cnt_d;
         digit_q      <= digit_d;
         seg_q        <= seg_d;
      end
   end

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver (8 digits, 4-cycle scan slots, 64-cycle blink).
module tb_seg_display_driver;

   logic        clk_100M = 1'b0;
   logic        reset;
   logic        load_valid;
   logic        load_ready;
   logic [31:0] number;
   logic        dec_mode;
   logic        blank_lz;
   logic [7:0]  blink_mask;
   logic [7:0]  dp;
   logic        busy;
   logic [7:0]  digit;
   logic [7:0]  segment;

   int checks = 0;
   int errors = 0;
   int n = 0;

   logic [7:0] exp_seg [8];
   bit         exp_vis [8];
   logic [7:0] bl_mask;

   seg_display_driver #(.DIGIT_CNT(8), .SCAN_DIV(4), .BLINK_DIV(64)) dut (
      .clk_100M  (clk_100M),
      .reset     (reset),
      .load_valid(load_valid),
      .load_ready(load_ready),
      .number    (number),
      .dec_mode  (dec_mode),
      .blank_lz  (blank_lz),
      .blink_mask(blink_mask),
      .dp        (dp),
      .busy      (busy),
      .digit     (digit),
      .segment   (segment)
   );

   always #5 clk_100M = ~clk_100M;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk_100M);
      #1;
      n++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic set_exp(input logic [63:0] segs, input logic [7:0] vis, input logic [7:0] bm);
      for (int i = 0; i < 8; i++) begin
         exp_seg[i] = segs[8*i +: 8];
         exp_vis[i] = vis[i];
      end
      bl_mask = bm;
   endtask

   // Outputs after edge n reflect the scan index and blink phase held after edge n-1.
   task automatic check_now(input string tag);
      int idx;
      bit ph;
      bit vis;
      idx = ((n - 1) / 4) % 8;
      ph  = (((n - 1) / 64) % 2) == 1;
      vis = exp_vis[idx] && !(ph && bl_mask[idx]);
      chk({tag, "_digit"}, {24'd0, digit}, vis ? (32'd1 << idx) : 32'd0);
      if (vis) chk({tag, "_seg"}, {24'd0, segment}, {24'd0, exp_seg[idx]});
   endtask

   task automatic sweep(input string tag, input int cyc);
      for (int k = 0; k < cyc; k++) begin
         step();
         check_now(tag);
      end
   endtask

   task automatic run_dec(input logic [31:0] val, input bit hold);
      int cnt;
      number     = val;
      dec_mode   = 1'b1;
      load_valid = 1'b1;
      chk("ready_idle", {31'd0, load_ready}, 32'd1);
      step();
      load_valid = 1'b0;
      chk("busy_start", {31'd0, busy}, 32'd1);
      if (hold) begin
         load_valid = 1'b1;
         dec_mode   = 1'b0;
         number     = 32'hFFFF_FFFF;
      end
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         cnt++;
         if (cnt == 10) begin
            chk("ready_convert", {31'd0, load_ready}, 32'd0);
            load_valid = 1'b0;
         end
         if (cnt == 20) check_now("hold_display");
         step();
      end
      chk("busy_len", cnt, 32'd33);
   endtask

   initial begin
      reset      = 1'b1;
      load_valid = 1'b0;
      number     = '0;
      dec_mode   = 1'b0;
      blank_lz   = 1'b0;
      blink_mask = '0;
      dp         = '0;
      set_exp({8{8'h3F}}, 8'hFF, 8'h00);
      step();
      step();
      reset = 1'b0;
      n = 0;
      chk("rst_ready", {31'd0, load_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_digit", {24'd0, digit}, 32'd1);
      chk("rst_seg", {24'd0, segment}, 32'h3F);

      // Hex load, no blanking
      number     = 32'h1234_ABCD;
      load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      chk("hex_ready", {31'd0, load_ready}, 32'd1);
      chk("hex_busy", {31'd0, busy}, 32'd0);
      step();
      set_exp(64'h06_5B_4F_66_77_7C_39_5E, 8'hFF, 8'h00);
      sweep("hex", 32);

      // Decimal 12345 with leading-zero blanking
      blank_lz = 1'b1;
      run_dec(32'd12345, 1'b0);
      set_exp(64'h00_00_00_06_5B_4F_66_6D, 8'h1F, 8'h00);
      sweep("dec12345", 32);

      // Overflow shows dashes everywhere
      run_dec(32'hFFFF_FFFF, 1'b0);
      set_exp({8{8'h40}}, 8'hFF, 8'h00);
      sweep("ovf", 32);

      // Zero keeps digit 0 only
      run_dec(32'd0, 1'b0);
      set_exp(64'h00_00_00_00_00_00_00_3F, 8'h01, 8'h00);
      sweep("zero", 32);

      // Blink digit 0, decimal point on digit 7
      blank_lz   = 1'b0;
      blink_mask = 8'h01;
      dp         = 8'h80;
      number     = 32'h1234_ABCD;
      dec_mode   = 1'b0;
      load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      step();
      set_exp(64'h86_5B_4F_66_77_7C_39_5E, 8'hFF, 8'h01);
      sweep("blink_dp", 128);

      // Requests while converting are ignored
      blank_lz   = 1'b1;
      blink_mask = 8'h00;
      dp         = 8'h00;
      run_dec(32'd99, 1'b1);
      set_exp(64'h00_00_00_00_00_00_6F_6F, 8'h03, 8'h00);
      sweep("held_valid", 32);

      // Reset at conversion cycle 10, with a competing load in the reset cycle
      number     = 32'd12345;
      dec_mode   = 1'b1;
      load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      for (int k = 0; k < 10; k++) step();
      chk("mid_busy", {31'd0, busy}, 32'd1);
      reset      = 1'b1;
      load_valid = 1'b1;
      dec_mode   = 1'b0;
      number     = 32'hFFFF_FFFF;
      step();
      reset      = 1'b0;
      load_valid = 1'b0;
      n = 0;
      chk("abort_ready", {31'd0, load_ready}, 32'd1);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_digit", {24'd0, digit}, 32'd1);
      chk("abort_seg", {24'd0, segment}, 32'h3F);
      set_exp({8{8'h3F}}, 8'hFF, 8'h00);
      sweep("abort", 72);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_display_driver.md
SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

Interface
REQ-001 SHALL have parameter DIGIT_CNT, default 8, number of seven-segment digits (legal range 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 100000, clk_100M cycles per digit scan slot (legal range 2 and up).
REQ-003 SHALL have parameter BLINK_DIV, default 25000000, clk_100M cycles per blink half-period (legal range 2 and up).
REQ-004 SHALL have port clk_100M, input, 1 bit: the only clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port load_valid, input, 1 bit: a new display request is presented.
REQ-007 SHALL have port load_ready, output, 1 bit: the block can accept a request.
REQ-008 SHALL have port number, input, 4*DIGIT_CNT bits: packed hex nibbles (hex mode) or unsigned binary value (dec mode).
REQ-009 SHALL have port dec_mode, input, 1 bit: 1 selects decimal display, 0 selects hex display.
REQ-010 SHALL have port blank_lz, input, 1 bit: 1 enables leading-zero blanking.
REQ-011 SHALL have port blink_mask, input, DIGIT_CNT bits: per-digit blink enable.
REQ-012 SHALL have port dp, input, DIGIT_CNT bits: per-digit decimal point.
REQ-013 SHALL have port busy, output, 1 bit: a decimal conversion is in progress.
REQ-014 SHALL have port digit, output, DIGIT_CNT bits: one-hot digit select, active-high.
REQ-015 SHALL have port segment, output, 8 bits: bits [6:0] drive segments a..g, bit [7] drives dp; all active-high.

Function
REQ-016 SHALL accept a request only in a cycle where load_valid=1 and load_ready=1, capturing number, dec_mode, blank_lz, blink_mask and dp in that cycle.
REQ-017 SHALL, for a hex-mode request, update the display register on the next edge after acceptance (latency 1) and keep load_ready=1 throughout.
REQ-018 SHALL implement FSM IDLE -> CONVERT -> UPDATE -> IDLE for dec-mode requests, with load_ready=1 only in IDLE and busy=1 in CONVERT and UPDATE.
REQ-019 SHALL perform CONVERT as shift-add-3 binary-to-BCD over exactly 4*DIGIT_CNT cycles, one input bit per cycle, MSB first.
REQ-020 SHALL write the display register in UPDATE, so a dec-mode result becomes visible 4*DIGIT_CNT+1 cycles after acceptance.
REQ-021 SHALL hold the previously displayed content unchanged while CONVERT is running.
REQ-022 SHALL hold the BCD result in DIGIT_CNT + DIGIT_CNT/4 + 1 digits, and flag overflow if any digit above index DIGIT_CNT-1 is nonzero.
REQ-023 SHALL, on overflow, show a dash (segments 0x40 plus dp) on every digit.
REQ-024 SHALL ignore load_valid while busy=1, with no effect on state or outputs.
REQ-025 SHALL run a scan counter from 0 to SCAN_DIV-1; on wrap, the digit index advances by 1, and from DIGIT_CNT-1 it wraps to 0.
REQ-026 SHALL run a blink counter from 0 to BLINK_DIV-1; on wrap, blink_phase toggles.
REQ-027 SHALL drive digit as a one-hot of the digit index, except that digit is all-zero for the current slot when that digit is blanked.
REQ-028 SHALL treat a digit as blanked if (a) blink_phase=1 and its blink_mask bit is 1, or (b) blank_lz=1, there is no overflow, the digit index is above 0, and that digit and all higher digits are 0.
REQ-029 SHALL always display digit 0 unless it is blink-blanked.
REQ-030 SHALL decode segments with this table: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-031 SHALL set segment[7] to the dp bit of the current digit.
REQ-032 SHALL register digit and segment, giving one cycle of latency from the index change to the outputs.
REQ-033 SHALL NOT reset or stall the scan and blink counters when a load is accepted.

Reset
REQ-034 SHALL, with reset=1 on an edge, clear the scan counter, blink counter, blink_phase, digit index, display register (all zeros), overflow, blink_mask, dp and blank_lz, select hex mode, and enter IDLE.
REQ-035 SHALL, after the reset edge, drive load_ready=1, busy=0, digit=1 and segment=0x3F.
REQ-036 SHALL abort any conversion in progress when reset is asserted mid-CONVERT, with no display update.
REQ-037 SHALL give reset priority over a load_valid presented in the same cycle.

Verification
Bench configuration: DIGIT_CNT=8, SCAN_DIV=4, BLINK_DIV=64.
REQ-038 SHALL cover: hex load 0x1234ABCD, blank_lz=0 -> digits 0..7 show D,C,B,A,4,3,2,1 (5E,39,7C,77,66,4F,5B,06), each for 4 cycles, scanning in order.
REQ-039 SHALL cover: dec load 12345, blank_lz=1 -> busy=1 for 33 cycles, then digits 0..4 show 5,4,3,2,1 and digits 5..7 have digit=0.
REQ-040 SHALL cover: dec load 0xFFFFFFFF -> overflow, all 8 digits show 0x40; a dec load of 0 with blank_lz=1 -> digit 0 shows 3F and digits 1..7 are blank.
REQ-041 SHALL cover: blink_mask=0x01 -> digit 0 is blanked in alternate 64-cycle phases; dp=0x80 -> segment[7]=1 only in slot 7.
REQ-042 SHALL cover: load_valid held during CONVERT -> ignored; reset at conversion cycle 10 -> IDLE, display all-zero, load_ready=1 on the next cycle.
